// File: rtl/qdr_sram_responder.sv
// qdr_sram_responder: single-clock QDRII+ burst SRAM responder; define QDR_ERR_INJ_EN to enable read-data error injection
module qdr_sram_responder #(
    parameter int DATA_WIDTH      = 36,
    parameter int BW_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 18,
    parameter int MEM_AW          = 10,
    parameter int BURST_LEN       = 2,
    parameter int RD_LATENCY      = 2,
    parameter int DLL_LOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  doff_n,
    input  logic                  r_n,
    input  logic                  w_n,
    input  logic [ADDR_WIDTH-1:0] sa,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [BW_WIDTH-1:0]   bw_n,
    input  logic                  inj_en,
    input  logic [MEM_AW-1:0]     inj_addr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  qvld,
    output logic                  ready,
    output logic                  cmd_err
);
    localparam int BB = $clog2(BURST_LEN);
    localparam int WA = MEM_AW + BB;
    localparam int LW = DATA_WIDTH / BW_WIDTH;
    localparam int CW = $clog2(DLL_LOCK_CYCLES) + 1;

    typedef enum logic {LOCKING, READY} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] mem [BURST_LEN << MEM_AW] = '{default: '0};
    logic [BURST_LEN-1:0][DATA_WIDTH-1:0] burst, rd_buf;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] pipe_d;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [BB-1:0] rd_beat, wr_beat;
    logic [MEM_AW-1:0] wr_addr;
    logic [WA-1:0] wa;
    logic [DATA_WIDTH-1:0] st_d;
    logic rdy, rd_act, wr_act, rd_acc, wr_acc, flip, st_v, unused_ok;

`ifdef QDR_ERR_INJ_EN
    assign flip = inj_en && sa[MEM_AW-1:0] == inj_addr;
    assign unused_ok = ^sa;
`else
    assign flip = 1'b0;
    assign unused_ok = ^{sa, inj_en, inj_addr};
`endif

    // Lock sequencing: count doff_n-high cycles in LOCKING, drop back whenever doff_n falls
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        if (!doff_n) begin
            state_nx = LOCKING;
            cnt_nx = '0;
        end else if (state == LOCKING) begin
            state_nx = (cnt == CW'(DLL_LOCK_CYCLES - 1)) ? READY : LOCKING;
            cnt_nx = (cnt == CW'(DLL_LOCK_CYCLES - 1)) ? '0 : cnt + 1'b1;
        end
        ready = state == READY;
        rdy = state == READY && doff_n;
    end

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOCKING;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    end

    assign rd_acc = rdy && !r_n && !rd_act;
    assign wr_acc = rdy && !w_n && r_n && !wr_act;
    assign wa = wr_acc ? {sa[MEM_AW-1:0], BB'(0)} : {wr_addr, wr_beat};
    assign st_v = rd_acc || rd_act;
    assign st_d = rd_acc ? burst[0] ^ {{(DATA_WIDTH-1){1'b0}}, flip} : rd_act ? rd_buf[rd_beat] : '0;
    assign q = pipe_d[RD_LATENCY-1];
    assign qvld = pipe_v[RD_LATENCY-1];

    // Whole burst is read at accept time so later commits never leak into it
    always_comb begin
        burst = '0;
        for (int k = 0; k < BURST_LEN; k++) burst[k] = mem[{sa[MEM_AW-1:0], BB'(k)}];
    end

    // Read port: hold the captured burst and step through beats 1..BURST_LEN-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_act <= 1'b0;
            rd_beat <= '0;
            rd_buf <= '0;
        end else if (rd_acc) begin
            rd_act <= 1'b1;
            rd_beat <= BB'(1);
            rd_buf <= burst;
        end else if (rd_act) begin
            rd_act <= rdy && rd_beat != BB'(BURST_LEN - 1);
            rd_beat <= rd_beat + 1'b1;
        end
    end

    // Read latency line; emptied whenever the DLL is not locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_d <= '0;
            pipe_v <= '0;
        end else if (!rdy) begin
            pipe_d <= '0;
            pipe_v <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_d[i] <= pipe_d[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
            pipe_d[0] <= st_d;
            pipe_v[0] <= st_v;
        end
    end

    // Write port: remember the burst address and current beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_act <= 1'b0;
            wr_beat <= '0;
            wr_addr <= '0;
        end else if (wr_acc) begin
            wr_act <= 1'b1;
            wr_beat <= BB'(1);
            wr_addr <= sa[MEM_AW-1:0];
        end else if (wr_act) begin
            wr_act <= rdy && wr_beat != BB'(BURST_LEN - 1);
            wr_beat <= wr_beat + 1'b1;
        end
    end

    // Array commit with per-lane byte-write masking; the array is deliberately outside reset
    always_ff @(posedge clk) begin
        if (wr_acc || (wr_act && rdy))
            for (int l = 0; l < BW_WIDTH; l++)
                if (!bw_n[l]) mem[wa][l*LW +: LW] <= d[l*LW +: LW];
    end

    // Illegal or dropped commands pulse cmd_err one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmd_err <= 1'b0;
        else cmd_err <= rdy ? (!r_n && rd_act) || (!w_n && (!r_n || wr_act)) : (!r_n || !w_n);
    end
endmodule

// File: tb/tb_qdr_sram_responder.sv
// tb_qdr_sram_responder: directed scoreboard bench for qdr_sram_responder
module tb_qdr_sram_responder;
    localparam int DW = 36, BWW = 4, AW = 18, MAW = 10, BL = 2, RL = 2, LK = 16, LW = DW / BWW;

    logic clk = 1'b0, rst_n = 1'b1, doff_n = 1'b1, r_n = 1'b1, w_n = 1'b1, inj_en = 1'b0;
    logic [AW-1:0] sa = '0;
    logic [DW-1:0] d = '0;
    logic [BWW-1:0] bw_n = '1;
    logic [MAW-1:0] inj_addr = '0;
    logic [DW-1:0] q;
    logic qvld, ready, cmd_err;
    int checks = 0, errors = 0, cyc = 0;

    typedef struct {int c; logic [DW-1:0] d;} exp_t;
    exp_t sb[$];
    logic [DW-1:0] mdl [BL << MAW];

    qdr_sram_responder #(
        .DATA_WIDTH(DW), .BW_WIDTH(BWW), .ADDR_WIDTH(AW), .MEM_AW(MAW),
        .BURST_LEN(BL), .RD_LATENCY(RL), .DLL_LOCK_CYCLES(LK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .doff_n(doff_n), .r_n(r_n), .w_n(w_n), .sa(sa), .d(d),
        .bw_n(bw_n), .inj_en(inj_en), .inj_addr(inj_addr), .q(q), .qvld(qvld),
        .ready(ready), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read-data monitor: pop scheduled beats on their cycle, otherwise require an idle bus
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].c == cyc) begin
            chk("qvld", 64'(qvld), 64'd1);
            chk("q", 64'(q), 64'(sb[0].d));
            void'(sb.pop_front());
        end else begin
            chk("qvld_idle", 64'(qvld), 64'd0);
            chk("q_idle", 64'(q), 64'd0);
        end
    end

    task automatic drv(input logic rn, input logic wn, input logic [AW-1:0] a,
                       input logic [DW-1:0] dd, input logic [BWW-1:0] bw);
        @(negedge clk);
        r_n = rn;
        w_n = wn;
        sa = a;
        d = dd;
        bw_n = bw;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b1, 1'b1, '0, '0, '1);
    endtask

    task automatic mwr(input int a, input logic [DW-1:0] dd, input logic [BWW-1:0] bw);
        for (int l = 0; l < BWW; l++) if (!bw[l]) mdl[a][l*LW +: LW] = dd[l*LW +: LW];
    endtask

    task automatic exp_rd(input int a, input logic flip);
        exp_t e;
        for (int k = 0; k < BL; k++) begin
            e.c = cyc + RL + k;
            e.d = mdl[a*BL + k] ^ {35'd0, flip && k == 0};
            sb.push_back(e);
        end
    endtask

    task automatic wr2(input int a, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [BWW-1:0] b0, input logic [BWW-1:0] b1);
        drv(1'b1, 1'b0, AW'(a), d0, b0);
        mwr(a*BL, d0, b0);
        drv(1'b1, 1'b1, '0, d1, b1);
        mwr(a*BL + 1, d1, b1);
        idle(1);
    endtask

    task automatic rd(input int a);
        drv(1'b0, 1'b1, AW'(a), '0, '1);
        exp_rd(a, 1'b0);
    endtask

    task automatic lock(input string tag);
        for (int i = 1; i <= LK; i++) begin
            @(negedge clk);
            chk(tag, 64'(ready), 64'(i == LK));
        end
    endtask

    initial begin
        logic inj;
`ifdef QDR_ERR_INJ_EN
        inj = 1'b1;
`else
        inj = 1'b0;
`endif
        for (int i = 0; i < (BL << MAW); i++) mdl[i] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_cmd_err", 64'(cmd_err), 64'd0);
        rst_n = 1'b1;
        lock("lock_after_reset");

        @(negedge clk);
        doff_n = 1'b0;
        drv(1'b0, 1'b1, 18'd5, '0, '1);
        chk("ready_doff_low", 64'(ready), 64'd0);
        idle(1);
        chk("cmd_err_locking", 64'(cmd_err), 64'd1);
        idle(1);
        chk("cmd_err_locking_pulse", 64'(cmd_err), 64'd0);
        doff_n = 1'b1;
        lock("lock_after_doff");

        wr2(5, 36'h123456789, 36'hABCDEF012, 4'b0000, 4'b0000);
        rd(5);
        idle(4);

        drv(1'b1, 1'b0, 18'd9, 36'h111111111, 4'b0000);
        mwr(18, 36'h111111111, 4'b0000);
        drv(1'b0, 1'b1, 18'd9, 36'h222222222, 4'b0000);
        exp_rd(9, 1'b0);
        mwr(19, 36'h222222222, 4'b0000);
        idle(4);
        rd(9);
        idle(4);

        wr2(3, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 4'b1110, 4'b1110);
        rd(3);
        idle(4);

        wr2(7, 36'h0AAAA5555, 36'h055550AAA, 4'b0000, 4'b0000);
        drv(1'b0, 1'b0, 18'd7, 36'h0DEADBEEF, 4'b0000);
        exp_rd(7, 1'b0);
        idle(1);
        chk("cmd_err_rw_same", 64'(cmd_err), 64'd1);
        idle(1);
        chk("cmd_err_rw_pulse", 64'(cmd_err), 64'd0);
        idle(2);
        rd(7);
        idle(4);

        drv(1'b1, 1'b0, 18'd12, 36'h0CAFEF00D, 4'b0000);
        mwr(24, 36'h0CAFEF00D, 4'b0000);
        drv(1'b1, 1'b0, 18'd13, 36'h012345678, 4'b0000);
        mwr(25, 36'h012345678, 4'b0000);
        idle(1);
        chk("cmd_err_wr_busy", 64'(cmd_err), 64'd1);
        idle(1);
        chk("cmd_err_wr_pulse", 64'(cmd_err), 64'd0);
        rd(13);
        idle(1);
        rd(12);
        idle(4);

        rd(5);
        drv(1'b0, 1'b1, 18'd7, '0, '1);
        rd(12);
        chk("cmd_err_rd_busy", 64'(cmd_err), 64'd1);
        idle(1);
        chk("cmd_err_rd_pulse", 64'(cmd_err), 64'd0);
        idle(4);

        rd(5);
        drv(1'b0, 1'b1, 18'd7, '0, '1);
        rd(12);
        idle(1);
        #2 rst_n = 1'b0;
        #1 chk("qvld_async_reset", 64'(qvld), 64'd0);
        chk("q_async_reset", 64'(q), 64'd0);
        chk("ready_async_reset", 64'(ready), 64'd0);
        sb.delete();
        @(negedge clk);
        r_n = 1'b1;
        w_n = 1'b1;
        rst_n = 1'b1;
        lock("lock_after_reset2");

        drv(1'b1, 1'b0, 18'd20, 36'h0F0F0F0F0, 4'b0000);
        mwr(40, 36'h0F0F0F0F0, 4'b0000);
        drv(1'b1, 1'b1, '0, 36'h777777777, 4'b0000);
        #2 rst_n = 1'b0;
        @(negedge clk);
        r_n = 1'b1;
        w_n = 1'b1;
        rst_n = 1'b1;
        lock("lock_after_reset3");
        rd(20);
        idle(4);

        inj_en = 1'b1;
        inj_addr = 10'd5;
        drv(1'b0, 1'b1, 18'd5, '0, '1);
        exp_rd(5, inj);
        idle(1);
        rd(7);
        idle(4);
        inj_en = 1'b0;

        idle(4);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
